// File: rtl/sample_pkg.sv
// Shared types and constants for the sample pipeline drain stage.
package sample_pkg;

  localparam int SAMPLE_W = 32;
  localparam int SEQ_W    = 16;

  typedef enum logic [0:0] {
    ACCUM = 1'b0,
    EMIT  = 1'b1
  } stage4_state_t;

endpackage

// File: rtl/sample_fifo.sv
// Circular-buffer FIFO with wrap-bit pointers; ignores push when full and pop when empty.
module sample_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Pointers carry one extra bit so full and empty are distinguishable when the indices match.
  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign level = wr_ptr - rd_ptr;
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/sample_stage4.sv
// Drain stage: buffers the unstallable to4_e stream, sums each group of GROUP entries
// and presents the sum on a valid/ready port, with sequence, drop and overflow status.
module sample_stage4
  import sample_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int DEPTH = 8,
  parameter int GROUP = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     to4_eValid,
  input  logic [WIDTH-1:0]         to4_e,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_sum,
  output logic [SEQ_W-1:0]         out_seq,
  output logic [15:0]              drop_cnt,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fifo_level
);

  localparam int GW = (GROUP > 1) ? $clog2(GROUP) : 1;
  localparam logic [GW-1:0] LAST = GW'(GROUP - 1);

  stage4_state_t    state;
  logic [WIDTH-1:0] acc;
  logic [GW-1:0]    grp_cnt;
  logic [WIDTH-1:0] head;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;
  logic             drop;

  // Full comes from the registered level, so a same-cycle pop never rescues a write.
  assign push = to4_eValid && !full;
  assign drop = to4_eValid && full;
  assign pop  = (state == ACCUM) && !empty;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (to4_e),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .level     (fifo_level)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      drop_cnt <= '0;
      overflow <= 1'b0;
    end else if (drop) begin
      if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ACCUM;
      acc       <= '0;
      grp_cnt   <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_seq   <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (pop) begin
            if (grp_cnt == LAST) begin
              out_sum   <= acc + head;
              out_valid <= 1'b1;
              acc       <= '0;
              grp_cnt   <= '0;
              state     <= EMIT;
            end else begin
              acc     <= acc + head;
              grp_cnt <= grp_cnt + GW'(1);
            end
          end
        end
        EMIT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_seq   <= out_seq + SEQ_W'(1);
            state     <= ACCUM;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_sample_stage4.sv
// Directed self-checking bench for sample_stage4 with hand-computed expectations.
module tb_sample_stage4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        to4_eValid = 1'b0;
  logic [31:0] to4_e = '0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_sum;
  logic [15:0] out_seq;
  logic [15:0] drop_cnt;
  logic        overflow;
  logic [3:0]  fifo_level;

  int assert_cnt = 0;
  int fail_cnt = 0;

  sample_stage4 #(.WIDTH(32), .DEPTH(8), .GROUP(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .to4_eValid (to4_eValid),
    .to4_e      (to4_e),
    .out_ready  (out_ready),
    .out_valid  (out_valid),
    .out_sum    (out_sum),
    .out_seq    (out_seq),
    .drop_cnt   (drop_cnt),
    .overflow   (overflow),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    assert_cnt++;
    if (actual !== expected) begin
      fail_cnt++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic valid, input logic [31:0] data, input logic ready);
    to4_eValid = valid;
    to4_e      = data;
    out_ready  = ready;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0);
    reset = 1'b0;
  endtask

  task automatic waitValid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !out_valid; i++) applyStimulus(1'b0, 32'd0, 1'b0);
    checkOutput(tag, 32'(out_valid), 32'd1);
  endtask

  initial begin
    // Reset state
    doReset();
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_sum", out_sum, 32'd0);
    checkOutput("rst_seq", 32'(out_seq), 32'd0);
    checkOutput("rst_drop", 32'(drop_cnt), 32'd0);
    checkOutput("rst_ovf", 32'(overflow), 32'd0);
    checkOutput("rst_level", 32'(fifo_level), 32'd0);

    // Basic group: last pop at the fifth edge raises out_valid for one cycle
    applyStimulus(1'b1, 32'd1, 1'b1);
    applyStimulus(1'b1, 32'd2, 1'b1);
    applyStimulus(1'b1, 32'd3, 1'b1);
    applyStimulus(1'b1, 32'd4, 1'b1);
    checkOutput("basic_not_yet", 32'(out_valid), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("basic_valid", 32'(out_valid), 32'd1);
    checkOutput("basic_sum", out_sum, 32'd10);
    checkOutput("basic_level", 32'(fifo_level), 32'd0);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("basic_valid_drop", 32'(out_valid), 32'd0);
    checkOutput("basic_seq", 32'(out_seq), 32'd1);

    // Backpressure and overflow
    doReset();
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 32'd1, 1'b0);
    checkOutput("bp_valid", 32'(out_valid), 32'd1);
    checkOutput("bp_sum", out_sum, 32'd4);
    checkOutput("bp_level", 32'(fifo_level), 32'd8);
    checkOutput("bp_drop", 32'(drop_cnt), 32'd2);
    checkOutput("bp_ovf", 32'(overflow), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_seq1", 32'(out_seq), 32'd1);
    waitValid("bp_wait2", 20);
    checkOutput("bp_sum2", out_sum, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    waitValid("bp_wait3", 20);
    checkOutput("bp_sum3", out_sum, 32'd4);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("bp_seq3", 32'(out_seq), 32'd3);
    checkOutput("bp_ovf_sticky", 32'(overflow), 32'd1);
    checkOutput("bp_drop_final", 32'(drop_cnt), 32'd2);
    checkOutput("bp_level_final", 32'(fifo_level), 32'd0);

    // Arithmetic wrap
    doReset();
    applyStimulus(1'b1, 32'hFFFF_FFFF, 1'b0);
    applyStimulus(1'b1, 32'd1, 1'b0);
    applyStimulus(1'b1, 32'd0, 1'b0);
    applyStimulus(1'b1, 32'd0, 1'b0);
    waitValid("wrap_wait", 10);
    checkOutput("wrap_sum", out_sum, 32'h0000_0000);

    // Reset mid-group discards partial accumulation
    doReset();
    applyStimulus(1'b1, 32'd7, 1'b1);
    applyStimulus(1'b1, 32'd7, 1'b1);
    doReset();
    checkOutput("midrst_level", 32'(fifo_level), 32'd0);
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("midrst_idle", 32'(out_valid), 32'd0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 32'd5, 1'b0);
    waitValid("midrst_wait", 10);
    checkOutput("midrst_sum", out_sum, 32'd20);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("midrst_seq", 32'(out_seq), 32'd1);

    // Full FIFO with handshake in the same cycle as a write
    doReset();
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 32'(i), 1'b0);
    waitValid("full_wait", 10);
    checkOutput("full_sum", out_sum, 32'd10);
    for (int i = 0; i < 8; i++) applyStimulus(1'b1, 32'd10, 1'b0);
    checkOutput("full_level8", 32'(fifo_level), 32'd8);
    checkOutput("full_nodrop", 32'(drop_cnt), 32'd0);
    applyStimulus(1'b1, 32'd9, 1'b1);
    checkOutput("full_drop", 32'(drop_cnt), 32'd1);
    checkOutput("full_ovf", 32'(overflow), 32'd1);
    checkOutput("full_level_hold", 32'(fifo_level), 32'd8);
    checkOutput("full_seq", 32'(out_seq), 32'd1);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("full_level_pop", 32'(fifo_level), 32'd7);
    waitValid("full_wait2", 10);
    checkOutput("full_sum2", out_sum, 32'd40);
    applyStimulus(1'b0, 32'd0, 1'b1);
    waitValid("full_wait3", 10);
    checkOutput("full_sum3", out_sum, 32'd40);
    applyStimulus(1'b0, 32'd0, 1'b1);
    checkOutput("full_empty", 32'(fifo_level), 32'd0);
    checkOutput("full_seq3", 32'(out_seq), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", assert_cnt, fail_cnt);
    $finish;
  end

endmodule
